// File: rtl/checkpoint_table.sv
// Branch checkpoint table: a circular FIFO of in-flight branches, retiring in order and
// rolling the active-list front back on a mispredict.

`ifndef AL_SIZE
`define AL_SIZE 32
`endif

module checkpoint_table #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(`AL_SIZE),
  localparam int unsigned IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_valid,
  input  logic [AW-1:0] alloc_front,
  output logic          alloc_ready,
  output logic [IW-1:0] alloc_id,
  input  logic          resolve_valid,
  input  logic [IW-1:0] resolve_id,
  input  logic          resolve_mispredict,
  output logic          restore_valid,
  output logic [AW-1:0] restore_front,
  output logic [IW-1:0] restore_id,
  output logic [IW:0]   count
);

  logic [IW-1:0]    r_head;
  logic [IW-1:0]    r_tail;
  logic [IW:0]      r_count;
  logic [DEPTH-1:0] r_live;
  logic [DEPTH-1:0] r_resolved;
  logic [AW-1:0]    r_front [DEPTH];
  logic             r_restore_valid;
  logic [AW-1:0]    r_restore_front;
  logic [IW-1:0]    r_restore_id;

  logic             w_res_live;
  logic             w_mispredict_req;
  logic             w_mispredict;
  logic             w_resolve_ok;
  logic             w_alloc;
  logic             w_retire;
  logic [IW-1:0]    w_k_dist;
  logic [IW-1:0]    w_idx_dist;
  logic [DEPTH-1:0] w_live_d;
  logic [DEPTH-1:0] w_resolved_d;

  assign w_res_live       = r_live[resolve_id];
  assign w_mispredict_req = resolve_valid && resolve_mispredict && w_res_live;
  assign w_mispredict     = w_mispredict_req && !r_restore_valid;
  assign w_resolve_ok     = resolve_valid && !resolve_mispredict && w_res_live && !r_restore_valid;
  assign w_k_dist         = resolve_id - r_head;

  assign alloc_ready = (r_count < (IW+1)'(DEPTH)) && !r_restore_valid && !w_mispredict_req;
  assign w_alloc     = alloc_valid && alloc_ready;

  // A mispredict on the head itself empties the table, so the head must not also advance.
  assign w_retire = r_live[r_head] && r_resolved[r_head] && !(w_mispredict && w_k_dist == '0);

  always_comb begin
    w_live_d     = r_live;
    w_resolved_d = r_resolved;
    w_idx_dist   = '0;
    if (w_retire) w_live_d[r_head] = 1'b0;
    if (w_mispredict) begin
      // Kill k and everything younger: distance from head at or beyond k's distance.
      for (int i = 0; i < DEPTH; i++) begin
        w_idx_dist = IW'(i) - r_head;
        if (w_idx_dist >= w_k_dist) w_live_d[i] = 1'b0;
      end
    end
    if (w_alloc) begin
      w_live_d[r_tail]     = 1'b1;
      w_resolved_d[r_tail] = 1'b0;
    end
    if (w_resolve_ok) w_resolved_d[resolve_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_live          <= '0;
      r_resolved      <= '0;
      r_restore_valid <= 1'b0;
      r_restore_front <= '0;
      r_restore_id    <= '0;
    end else begin
      r_live          <= w_live_d;
      r_resolved      <= w_resolved_d;
      r_restore_valid <= w_mispredict;
      if (w_retire) r_head <= r_head + 1'b1;
      if (w_mispredict) begin
        r_restore_front <= r_front[resolve_id];
        r_restore_id    <= resolve_id;
        r_tail          <= resolve_id;
        r_count         <= (w_k_dist == '0) ? '0 : {1'b0, w_k_dist} - (IW+1)'(w_retire);
      end else begin
        if (w_alloc) r_tail <= r_tail + 1'b1;
        r_count <= r_count + (IW+1)'(w_alloc) - (IW+1)'(w_retire);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc) r_front[r_tail] <= alloc_front;
  end

  assign alloc_id      = r_tail;
  assign count         = r_count;
  assign restore_valid = r_restore_valid;
  assign restore_front = r_restore_front;
  assign restore_id    = r_restore_id;

endmodule
